csi_lane_distributor: RTL and testbench

CSI_LANE_DISTRIBUTOR -- requirements
Module: csi_lane_distributor

---
 rtl/csi_lane_distributor.sv | 136 +++++++++++++
 tb/tb_csi_lane_distributor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_lane_distributor.sv
// CSI-2 lane distributor: spreads packet beats across D-PHY data lanes and frames each
// burst with HS request, sync byte and per-lane trailer sequences.
module csi_lane_distributor #(
  parameter int LANES         = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int TRAIL_CYCLES  = 2
) (
  input  logic                 hs_clk,
  input  logic                 rst_n,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_strb,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [LANES-1:0]     hs_req,
  output logic [8*LANES-1:0]   hs_data,
  output logic [LANES-1:0]     hs_valid,
  output logic                 busy,
  output logic                 err_underflow
);

  typedef enum logic [2:0] {IDLE, REQ, SYNC, DATA, TRAIL, EXIT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [8*LANES-1:0] last_q, last_nxt;
  logic [8*LANES-1:0] data_nxt;
  logic [LANES-1:0]   valid_nxt;
  logic               req_nxt, err_nxt;

  function automatic logic [7:0] trailer_of(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        if (cnt == 4'(SETTLE_CYCLES - 1)) begin
          state_nxt = SYNC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SYNC: state_nxt = DATA;
      DATA: begin
        if (in_valid && in_last) begin
          state_nxt = TRAIL;
          cnt_nxt   = '0;
        end
      end
      TRAIL: begin
        if (cnt == 4'(TRAIL_CYCLES - 1)) begin
          state_nxt = EXIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      EXIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane outputs are computed from the current state and registered, so the
  // visible lane sequence trails the state sequence by one cycle.
  always_comb begin
    req_nxt   = (state == REQ) || (state == SYNC) || (state == DATA) || (state == TRAIL);
    valid_nxt = '0;
    data_nxt  = '0;
    last_nxt  = last_q;
    err_nxt   = err_underflow;
    case (state)
      SYNC: begin
        valid_nxt = '1;
        data_nxt  = {LANES{8'hB8}};
      end
      DATA: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (in_strb[k]) begin
              valid_nxt[k]          = 1'b1;
              data_nxt[8*k +: 8]    = in_data[8*k +: 8];
              last_nxt[8*k +: 8]    = in_data[8*k +: 8];
            end else if (in_last) begin
              valid_nxt[k]          = 1'b1;
              data_nxt[8*k +: 8]    = trailer_of(last_q[8*k +: 8]);
            end
          end
        end else begin
          err_nxt = 1'b1;
        end
      end
      TRAIL: begin
        valid_nxt = '1;
        for (int unsigned k = 0; k < LANES; k++) begin
          data_nxt[8*k +: 8] = trailer_of(last_q[8*k +: 8]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_q        <= '0;
      hs_req        <= '0;
      hs_valid      <= '0;
      hs_data       <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      last_q        <= last_nxt;
      hs_req        <= {LANES{req_nxt}};
      hs_valid      <= valid_nxt;
      hs_data       <= data_nxt;
      in_ready      <= (state_nxt == DATA);
      busy          <= (state_nxt != IDLE);
      err_underflow <= err_nxt;
    end
  end

endmodule

// File: tb/tb_csi_lane_distributor.sv
// Self-checking bench for csi_lane_distributor (4 lanes): each packet is expanded into a
// per-cycle expected lane timeline from the framing rules and compared cycle by cycle.
module tb_csi_lane_distributor;
  localparam int LANES  = 4;
  localparam int SETTLE = 4;
  localparam int TRAIL  = 2;

  logic        hs_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_strb = '0;
  logic        in_valid = 1'b0;
  logic        in_last  = 1'b0;
  logic        in_ready;
  logic [3:0]  hs_req;
  logic [31:0] hs_data;
  logic [3:0]  hs_valid;
  logic        busy;
  logic        err_underflow;

  always #5 hs_clk = ~hs_clk;

  csi_lane_distributor #(
    .LANES(LANES),
    .SETTLE_CYCLES(SETTLE),
    .TRAIL_CYCLES(TRAIL)
  ) dut (
    .hs_clk(hs_clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_strb(in_strb),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .hs_req(hs_req),
    .hs_data(hs_data),
    .hs_valid(hs_valid),
    .busy(busy),
    .err_underflow(err_underflow)
  );

  int tests = 0;
  int fails = 0;

  // reference model state: last byte emitted per lane, sticky underflow flag
  logic [7:0]  stored [4];
  bit          err_m;
  logic [31:0] b_data [8];
  logic [3:0]  b_strb [8];
  int          nbeats;

  function automatic logic [7:0] trl(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},   {28'b0, hs_req},   32'h0);
    chk({tag, "_valid"}, {28'b0, hs_valid}, 32'h0);
    chk({tag, "_data"},  hs_data,           32'h0);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'h0);
    chk({tag, "_busy"},  {31'b0, busy},     32'h0);
    chk({tag, "_err"},   {31'b0, err_underflow}, 32'h0);
  endtask

  // Runs one packet from b_data/b_strb. gap_before inserts one in_valid=0 cycle
  // ahead of that beat index; hold keeps in_valid high after the last beat;
  // abort_trail pulses reset at the first trailer cycle.
  task automatic run_pkt(input bit hold, input int gap_before, input bit abort_trail);
    logic        iv [16];
    logic [31:0] id [16];
    logic [3:0]  is_ [16];
    logic        il [16];
    logic [3:0]  er [32];
    logic [3:0]  ev [32];
    logic [31:0] ed [32];
    logic        erdy [32];
    logic        ebusy [32];
    logic        eerr [32];
    int d, gap_d, nd, len, jd;

    d = 0;
    gap_d = -1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_before) begin
        iv[d] = 1'b0; id[d] = '0; is_[d] = '0; il[d] = 1'b0; gap_d = d; d++;
      end
      iv[d] = 1'b1; id[d] = b_data[b]; is_[d] = b_strb[b]; il[d] = (b == nbeats - 1); d++;
    end
    nd  = d;
    len = SETTLE + 3 + nd + TRAIL;

    for (int j = 0; j < len; j++) begin
      er[j] = '0; ev[j] = '0; ed[j] = '0;
      erdy[j]  = (j >= SETTLE + 2) && (j <= SETTLE + 1 + nd);
      ebusy[j] = (j >= 1) && (j <= SETTLE + 2 + nd + TRAIL);
      eerr[j]  = err_m || ((gap_d >= 0) && (j >= SETTLE + 3 + gap_d));
    end
    for (int j = 2; j <= SETTLE + 1; j++) er[j] = '1;
    er[SETTLE + 2] = '1;
    ev[SETTLE + 2] = '1;
    ed[SETTLE + 2] = {4{8'hB8}};
    for (int i = 0; i < nd; i++) begin
      jd = SETTLE + 3 + i;
      er[jd] = '1;
      if (iv[i]) begin
        for (int k = 0; k < LANES; k++) begin
          if (is_[i][k]) begin
            ev[jd][k] = 1'b1;
            ed[jd][8*k +: 8] = id[i][8*k +: 8];
            stored[k] = id[i][8*k +: 8];
          end else if (il[i]) begin
            ev[jd][k] = 1'b1;
            ed[jd][8*k +: 8] = trl(stored[k]);
          end
        end
      end
    end
    for (int t = 0; t < TRAIL; t++) begin
      jd = SETTLE + 3 + nd + t;
      er[jd] = '1;
      ev[jd] = '1;
      for (int k = 0; k < LANES; k++) ed[jd][8*k +: 8] = trl(stored[k]);
    end

    for (int j = 0; j < len; j++) begin
      @(negedge hs_clk);
      chk($sformatf("hs_req[c%0d]", j),   {28'b0, hs_req},   {28'b0, er[j]});
      chk($sformatf("hs_valid[c%0d]", j), {28'b0, hs_valid}, {28'b0, ev[j]});
      chk($sformatf("hs_data[c%0d]", j),  hs_data,           ed[j]);
      chk($sformatf("in_ready[c%0d]", j), {31'b0, in_ready}, {31'b0, erdy[j]});
      chk($sformatf("busy[c%0d]", j),     {31'b0, busy},     {31'b0, ebusy[j]});
      chk($sformatf("err[c%0d]", j),      {31'b0, err_underflow}, {31'b0, eerr[j]});
      if (abort_trail && (j == SETTLE + 3 + nd)) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_zero_outputs("abort_async");
        @(negedge hs_clk);
        chk_zero_outputs("abort_held");
        rst_n = 1'b1;
        for (int k = 0; k < LANES; k++) stored[k] = '0;
        err_m = 1'b0;
        return;
      end
      if (j < SETTLE + 2) begin
        in_valid = 1'b1; in_data = b_data[0]; in_strb = b_strb[0]; in_last = (nbeats == 1);
      end else if (j < SETTLE + 2 + nd) begin
        in_valid = iv[j-SETTLE-2]; in_data = id[j-SETTLE-2];
        in_strb  = is_[j-SETTLE-2]; in_last = il[j-SETTLE-2];
      end else begin
        in_valid = hold; in_data = $urandom; in_strb = '1; in_last = 1'b0;
      end
    end
    if (gap_d >= 0) err_m = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hs_clk);
      chk("idle_req",   {28'b0, hs_req},   32'h0);
      chk("idle_valid", {28'b0, hs_valid}, 32'h0);
      chk("idle_ready", {31'b0, in_ready}, 32'h0);
      chk("idle_busy",  {31'b0, busy},     32'h0);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, gsel;
    for (int i = 0; i < LANES; i++) stored[i] = '0;
    err_m = 1'b0;

    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge hs_clk);
    chk_zero_outputs("reset_held");
    rst_n = 1'b1;
    idle_cycles(2);

    // single full beat
    nbeats = 1; b_data[0] = 32'h9A561234; b_strb[0] = 4'b1111;
    run_pkt(1'b0, -1, 1'b0);
    idle_cycles(2);

    // three beats, partial last beat with lane1 = 8'h80
    nbeats = 3;
    b_data[0] = 32'h11223344; b_strb[0] = 4'b1111;
    b_data[1] = 32'h55667788; b_strb[1] = 4'b1111;
    b_data[2] = 32'hAAAA8001; b_strb[2] = 4'b0011;
    run_pkt(1'b0, -1, 1'b0);
    idle_cycles(1);

    // empty last beat: every lane emits its trailer
    nbeats = 2;
    b_data[0] = 32'h7F80017E; b_strb[0] = 4'b1111;
    b_data[1] = 32'hDEADBEEF; b_strb[1] = 4'b0000;
    run_pkt(1'b0, -1, 1'b0);
    idle_cycles(1);

    // one-cycle starvation inside DATA
    nbeats = 3;
    b_data[0] = 32'h01020304; b_strb[0] = 4'b1111;
    b_data[1] = 32'h8090A0B0; b_strb[1] = 4'b1111;
    b_data[2] = 32'h00C0FFEE; b_strb[2] = 4'b0111;
    run_pkt(1'b0, 1, 1'b0);
    idle_cycles(2);

    // reset during TRAIL, then a clean packet
    nbeats = 2;
    b_data[0] = 32'hF0E0D0C0; b_strb[0] = 4'b1111;
    b_data[1] = 32'h12345678; b_strb[1] = 4'b1111;
    run_pkt(1'b0, -1, 1'b1);
    nbeats = 1; b_data[0] = 32'h00FF7F80; b_strb[0] = 4'b0111;
    run_pkt(1'b0, -1, 1'b0);
    idle_cycles(1);

    // back-to-back packets with in_valid held high across the gap
    nbeats = 2;
    b_data[0] = 32'h13579BDF; b_strb[0] = 4'b1111;
    b_data[1] = 32'h2468ACE0; b_strb[1] = 4'b0001;
    run_pkt(1'b1, -1, 1'b0);
    nbeats = 1; b_data[0] = 32'h89ABCDEF; b_strb[0] = 4'b1111;
    run_pkt(1'b0, -1, 1'b0);
    idle_cycles(1);

    for (int p = 0; p < 20; p++) begin
      nbeats = 1 + int'($urandom_range(3));
      for (int b = 0; b < nbeats; b++) begin
        b_data[b] = $urandom;
        b_strb[b] = 4'b1111;
      end
      k = int'($urandom_range(4));
      b_strb[nbeats-1] = 4'((1 << k) - 1);
      gsel = ($urandom_range(3) == 0) ? int'($urandom_range(nbeats - 1)) : -1;
      run_pkt(bit'($urandom_range(1)), gsel, 1'b0);
      if ($urandom_range(1) == 1) idle_cycles(1 + int'($urandom_range(2)));
    end
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
